// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with phase-coherent restart and lock indication.
// All channels reload their phase together in ALIGN, then settle for LOCK_CYC+1 cycles in WARM.
module clk_div_gen #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int LOCK_CYC = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [NUM_CH*CNT_W-1:0] cfg_div,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_stb,
  output logic                    locked
);

  localparam int SET_W = $clog2(LOCK_CYC + 1);
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(LOCK_CYC);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    WARM,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   div_q     [NUM_CH];
  logic [CNT_W-1:0]   div_d     [NUM_CH];
  logic [CNT_W-1:0]   phase_q   [NUM_CH];
  logic [CNT_W-1:0]   phase_d   [NUM_CH];
  logic [CNT_W-1:0]   cnt_q     [NUM_CH];
  logic [CNT_W-1:0]   cnt_d     [NUM_CH];
  logic [CNT_W-1:0]   eff_div   [NUM_CH];
  logic [CNT_W-1:0]   eff_phase [NUM_CH];
  logic [NUM_CH-1:0]  clk_out_q, clk_out_d;
  logic [NUM_CH-1:0]  clk_stb_q, clk_stb_d;
  logic               accept;
  logic               run_d;

  // Reset gates the handshake and lock flag immediately, before the state register clears.
  assign cfg_ready = !reset && ((state_q == IDLE) || (state_q == LOCKED));
  assign locked    = !reset && (state_q == LOCKED);
  assign accept    = cfg_valid && cfg_ready;
  assign clk_out   = clk_out_q;
  assign clk_stb   = clk_stb_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]     = accept ? cfg_div[i*CNT_W +: CNT_W]   : div_q[i];
      phase_d[i]   = accept ? cfg_phase[i*CNT_W +: CNT_W] : phase_q[i];
      eff_div[i]   = (div_q[i] < CNT_W'(2)) ? CNT_W'(2) : div_q[i];
      eff_phase[i] = (phase_q[i] >= eff_div[i]) ? '0 : phase_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ALIGN;
      ALIGN:   state_d = WARM;
      WARM:    if (settle_q == SETTLE_MAX) state_d = LOCKED;
      LOCKED:  if (accept) state_d = ALIGN;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
    settle_d = ((state_q == WARM) && (state_d == WARM)) ? settle_q + SET_W'(1) : '0;
  end

  // Outputs are computed from next-cycle counter values so each output bit is a plain flop.
  always_comb begin
    run_d     = (state_d == WARM) || (state_d == LOCKED);
    clk_out_d = '0;
    clk_stb_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      case (state_q)
        ALIGN:        cnt_d[i] = eff_phase[i];
        WARM, LOCKED: cnt_d[i] = (cnt_q[i] >= eff_div[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
        default:      cnt_d[i] = cnt_q[i];
      endcase
      clk_out_d[i] = run_d && (cnt_d[i] < (eff_div[i] >> 1));
      clk_stb_d[i] = run_d && (cnt_d[i] == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      clk_out_q <= '0;
      clk_stb_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= CNT_W'(2);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      clk_out_q <= clk_out_d;
      clk_stb_q <= clk_stb_d;
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: expected per-cycle outputs are queued from a cycle-index model
// when a run is started and popped against the DUT after every rising edge.
module tb_clk_div_gen;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 8;
  localparam int LOCK_CYC = 16;

  typedef struct packed {
    logic [1:0] out;
    logic [1:0] stb;
    logic       lock;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [15:0] cfg_phase;
  logic [1:0]  clk_out;
  logic [1:0]  clk_stb;
  logic        locked;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e;

  always #5 sys_clk = ~sys_clk;

  clk_div_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOCK_CYC(LOCK_CYC)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .clk_out  (clk_out),
    .clk_stb  (clk_stb),
    .locked   (locked)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_cfg(input int d0, input int p0, input int d1, input int p1);
    cfg_div   = {8'(d1), 8'(d0)};
    cfg_phase = {8'(p1), 8'(p0)};
  endtask

  // k is the cycle index after the ALIGN cycle; k=0 is the first cycle with counters at phase.
  task automatic push_seq(input int d0, input int p0, input int d1, input int p1,
                          input int n, input int k0);
    int   d[2];
    int   p[2];
    int   c;
    exp_t x;
    d[0] = (d0 < 2) ? 2 : d0;
    d[1] = (d1 < 2) ? 2 : d1;
    p[0] = (p0 >= d[0]) ? 0 : p0;
    p[1] = (p1 >= d[1]) ? 0 : p1;
    for (int k = k0; k < k0 + n; k++) begin
      x = '0;
      for (int i = 0; i < 2; i++) begin
        c        = (p[i] + k) % d[i];
        x.out[i] = (c < d[i] / 2);
        x.stb[i] = (c == 0);
      end
      x.lock = (k >= LOCK_CYC + 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    enable    = 1'b1;
    cfg_valid = 1'b1;
    set_cfg(7, 3, 9, 4);
    step();
    step();
    checks++;
    if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold out=%b stb=%b locked=%b ready=%b required 00 00 0 0",
               clk_out, clk_stb, locked, cfg_ready);
    end
    reset     = 1'b0;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    #1;
    checks++;
    if (cfg_ready !== 1'b1 || locked !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release ready=%b locked=%b required 1 0", cfg_ready, locked);
    end
  endtask

  task automatic test_default();
    enable = 1'b1;
    step();
    checks++;
    if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL default_align out=%b stb=%b locked=%b ready=%b required 00 00 0 0",
               clk_out, clk_stb, locked, cfg_ready);
    end
    push_seq(2, 0, 2, 0, 25, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock || cfg_ready !== e.lock) begin
        failures++;
        $display("[TB] FAIL default_run k=%0d out=%b/%b stb=%b/%b locked=%b/%b ready=%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock, cfg_ready);
      end
    end
    enable = 1'b0;
    step();
    checks++;
    if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL default_stop out=%b stb=%b locked=%b ready=%b required 00 00 0 1",
               clk_out, clk_stb, locked, cfg_ready);
    end
  endtask

  task automatic test_phase();
    set_cfg(2, 0, 4, 2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    enable    = 1'b1;
    step();
    push_seq(2, 0, 4, 2, 20, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock || cfg_ready !== e.lock) begin
        failures++;
        $display("[TB] FAIL phase_run k=%0d out=%b/%b stb=%b/%b locked=%b/%b ready=%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock, cfg_ready);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_boundary();
    int bd0[3] = '{5, 1, 3};
    int bp0[3] = '{0, 1, 2};
    int bd1[3] = '{0, 4, 255};
    int bp1[3] = '{0, 7, 0};
    int bn[3]  = '{30, 30, 520};
    for (int t = 0; t < 3; t++) begin
      set_cfg(bd0[t], bp0[t], bd1[t], bp1[t]);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      enable    = 1'b1;
      step();
      push_seq(bd0[t], bp0[t], bd1[t], bp1[t], bn[t], 0);
      for (int k = 0; exp_q.size() > 0; k++) begin
        step();
        e = exp_q.pop_front();
        checks++;
        if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock || cfg_ready !== e.lock) begin
          failures++;
          $display("[TB] FAIL boundary%0d k=%0d out=%b/%b stb=%b/%b locked=%b/%b ready=%b (got/required)",
                   t, k, clk_out, e.out, clk_stb, e.stb, locked, e.lock, cfg_ready);
        end
      end
      enable = 1'b0;
      step();
    end
  endtask

  task automatic test_back_to_back();
    set_cfg(2, 0, 4, 2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    enable    = 1'b1;
    step();
    push_seq(2, 0, 4, 2, 20, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock) begin
        failures++;
        $display("[TB] FAIL b2b_prelock k=%0d out=%b/%b stb=%b/%b locked=%b/%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock);
      end
    end
    set_cfg(3, 1, 6, 5);
    cfg_valid = 1'b1;
    step();
    checks++;
    if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_accept out=%b stb=%b locked=%b ready=%b required 00 00 0 0",
               clk_out, clk_stb, locked, cfg_ready);
    end
    set_cfg(9, 4, 7, 6);
    push_seq(3, 1, 6, 5, LOCK_CYC + 2, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock || cfg_ready !== e.lock) begin
        failures++;
        $display("[TB] FAIL b2b_reload k=%0d out=%b/%b stb=%b/%b locked=%b/%b ready=%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock, cfg_ready);
      end
      if (e.lock) cfg_valid = 1'b0;
    end
    push_seq(3, 1, 6, 5, 10, LOCK_CYC + 2);
    for (int k = LOCK_CYC + 2; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock || cfg_ready !== e.lock) begin
        failures++;
        $display("[TB] FAIL b2b_after k=%0d out=%b/%b stb=%b/%b locked=%b/%b ready=%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock, cfg_ready);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    repeat (7) step();
    enable = 1'b0;
    step();
    checks++;
    if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_warm out=%b stb=%b locked=%b ready=%b required 00 00 0 1",
               clk_out, clk_stb, locked, cfg_ready);
    end
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if (locked !== 1'b0 || clk_out !== 2'b00) begin
        failures++;
        $display("[TB] FAIL drop_idle k=%0d locked=%b out=%b required 0 00", k, locked, clk_out);
      end
    end
    enable = 1'b1;
    step();
    push_seq(3, 1, 6, 5, 19, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock) begin
        failures++;
        $display("[TB] FAIL drop_relock k=%0d out=%b/%b stb=%b/%b locked=%b/%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock);
      end
    end
    set_cfg(2, 1, 5, 3);
    cfg_valid = 1'b1;
    enable    = 1'b0;
    step();
    cfg_valid = 1'b0;
    checks++;
    if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drop_with_cfg out=%b stb=%b locked=%b ready=%b required 00 00 0 1",
               clk_out, clk_stb, locked, cfg_ready);
    end
    enable = 1'b1;
    step();
    push_seq(2, 1, 5, 3, 8, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock) begin
        failures++;
        $display("[TB] FAIL drop_cfg_kept k=%0d out=%b/%b stb=%b/%b locked=%b/%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock);
      end
    end
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    set_cfg(6, 2, 7, 3);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    enable    = 1'b1;
    step();
    repeat (LOCK_CYC + 4) step();
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rmid_prelock locked=%b required 1", locked);
    end
    reset     = 1'b1;
    cfg_valid = 1'b1;
    set_cfg(9, 4, 11, 5);
    #1;
    checks++;
    if (locked !== 1'b0 || cfg_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rmid_assert locked=%b ready=%b required 0 0", locked, cfg_ready);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (clk_out !== 2'b00 || clk_stb !== 2'b00 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rmid_hold k=%0d out=%b stb=%b locked=%b ready=%b required 00 00 0 0",
                 k, clk_out, clk_stb, locked, cfg_ready);
      end
    end
    reset     = 1'b0;
    cfg_valid = 1'b0;
    step();
    push_seq(2, 0, 2, 0, 24, 0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.out || clk_stb !== e.stb || locked !== e.lock || cfg_ready !== e.lock) begin
        failures++;
        $display("[TB] FAIL rmid_default k=%0d out=%b/%b stb=%b/%b locked=%b/%b ready=%b (got/required)",
                 k, clk_out, e.out, clk_stb, e.stb, locked, e.lock, cfg_ready);
      end
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_phase = '0;
    test_reset();
    test_default();
    test_phase();
    test_boundary();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
